// File: rtl/mvu_pkg.sv
// Shared MVU types and widths for the input and output address generators.
// Used by inagu and outagu.
package mvu_pkg;

    localparam int BDBANKA = 15;
    localparam int BSTRIDE = 15;
    localparam int BLENGTH = 15;

    typedef logic [BDBANKA-1:0] addr_t;
    typedef logic [BSTRIDE-1:0] stride_t;
    typedef logic [BLENGTH-1:0] len_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } agu_state_e;

    // Two's-complement stride widened or narrowed to address width.
    function automatic addr_t sext_stride(input stride_t s);
        return addr_t'(signed'(s));
    endfunction

endpackage

// File: rtl/inagu_dimcnt.sv
// One loop dimension: iteration counter with clear, increment and
// end-of-dimension compare.
module inagu_dimcnt
    import mvu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    input  len_t len_i,
    output len_t cnt_o,
    output logic wrap_o
);

    len_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + len_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = (cnt_q == len_i);

endmodule

// File: rtl/inagu.sv
// Input address generator: 3-level nested walk over data-memory addresses.
// INAGU_ZIGZAG_EN enables serpentine traversal of dimension 0.
module inagu
    import mvu_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  logic    step,
    input  addr_t   baseaddr,
    input  stride_t stride_0,
    input  stride_t stride_1,
    input  stride_t stride_2,
    input  len_t    length_0,
    input  len_t    length_1,
    input  len_t    length_2,
    output addr_t   addr_out,
    output logic    valid,
    output logic    last,
    output logic    done
);

    agu_state_e state_q, state_d;
    addr_t addr_q, addr_d;
    addr_t row_q, row_d;
    addr_t plane_q, plane_d;
    logic  done_q, done_d;
    addr_t s0_q, s1_q, s2_q;
    len_t  l0_q, l1_q, l2_q;

    logic w0, w1, w2;
    logic run, adv, fin;
    logic inc0, inc1, inc2;
    len_t c0, c1, c2;

    assign run  = (state_q == RUN);
    assign last = run && w0 && w1 && w2;
    assign adv  = step && run && !load && !last;
    assign fin  = step && !load && last;
    assign inc0 = adv && !w0;
    assign inc1 = adv && w0 && !w1;
    assign inc2 = adv && w0 && w1 && !w2;

    inagu_dimcnt u_d0 (
        .clk(clk), .rst(rst),
        .clr_i(load || (adv && w0)), .inc_i(inc0),
        .len_i(l0_q), .cnt_o(c0), .wrap_o(w0)
    );

    inagu_dimcnt u_d1 (
        .clk(clk), .rst(rst),
        .clr_i(load || (adv && w0 && w1)), .inc_i(inc1),
        .len_i(l1_q), .cnt_o(c1), .wrap_o(w1)
    );

    inagu_dimcnt u_d2 (
        .clk(clk), .rst(rst),
        .clr_i(load), .inc_i(inc2),
        .len_i(l2_q), .cnt_o(c2), .wrap_o(w2)
    );

`ifdef INAGU_ZIGZAG_EN
    logic dir_q, dir_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        row_d   = row_q;
        plane_d = plane_q;
        done_d  = 1'b0;
`ifdef INAGU_ZIGZAG_EN
        dir_d   = dir_q;
`endif
        if (load) begin
            state_d = RUN;
            addr_d  = baseaddr;
            row_d   = baseaddr;
            plane_d = baseaddr;
`ifdef INAGU_ZIGZAG_EN
            dir_d   = 1'b0;
`endif
        end else if (fin) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end else if (inc0) begin
`ifdef INAGU_ZIGZAG_EN
            addr_d = dir_q ? addr_q - s0_q : addr_q + s0_q;
`else
            addr_d = addr_q + s0_q;
`endif
        end else if (inc1) begin
`ifdef INAGU_ZIGZAG_EN
            // Serpentine: next row starts where this one ended.
            addr_d = addr_q + s1_q;
            dir_d  = !dir_q;
`else
            addr_d = row_q + s1_q;
`endif
            row_d = addr_d;
        end else if (inc2) begin
            addr_d  = plane_q + s2_q;
            row_d   = addr_d;
            plane_d = addr_d;
`ifdef INAGU_ZIGZAG_EN
            dir_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            row_q   <= '0;
            plane_q <= '0;
            done_q  <= 1'b0;
            s0_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            l0_q    <= '0;
            l1_q    <= '0;
            l2_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            done_q  <= done_d;
            if (load) begin
                s0_q <= sext_stride(stride_0);
                s1_q <= sext_stride(stride_1);
                s2_q <= sext_stride(stride_2);
                l0_q <= length_0;
                l1_q <= length_1;
                l2_q <= length_2;
            end
        end
    end

`ifdef INAGU_ZIGZAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`endif

    assign addr_out = addr_q;
    assign valid    = run;
    assign done     = done_q;

    logic unused;
    assign unused = ^{c0, c1, c2};

endmodule

// File: tb/tb_inagu.sv
// Scoreboard bench for inagu: expected outputs are queued with each driven
// cycle and popped after the following clock edge.
module tb_inagu;
    import mvu_pkg::*;

    typedef struct packed {
        logic [14:0] addr;
        logic        v;
        logic        l;
        logic        d;
    } exp_t;

    logic    clk = 1'b0;
    logic    rst;
    logic    load, step;
    addr_t   baseaddr;
    stride_t stride_0, stride_1, stride_2;
    len_t    length_0, length_1, length_2;
    addr_t   addr_out;
    logic    valid, last, done;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];
    logic [14:0] wq[$];

    always #5 clk = ~clk;

    inagu dut (
        .clk(clk), .rst(rst), .load(load), .step(step),
        .baseaddr(baseaddr),
        .stride_0(stride_0), .stride_1(stride_1), .stride_2(stride_2),
        .length_0(length_0), .length_1(length_1), .length_2(length_2),
        .addr_out(addr_out), .valid(valid), .last(last), .done(done)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic ld, input logic st, input exp_t e);
        exp_t x;
        load = ld;
        step = st;
        sb.push_back(e);
        @(posedge clk);
        #1;
        load = 1'b0;
        step = 1'b0;
        x = sb.pop_front();
        chk("addr", int'(addr_out), int'(x.addr));
        chk("valid", int'(valid), int'(x.v));
        chk("last", int'(last), int'(x.l));
        chk("done", int'(done), int'(x.d));
    endtask

    // Reference walk from closed-form nested loops.
    task automatic gen(input int b, input int s0, input int s1, input int s2,
                       input int l0, input int l1, input int l2, input bit zz);
        int k;
        wq.delete();
        for (int i2 = 0; i2 <= l2; i2++)
            for (int i1 = 0; i1 <= l1; i1++)
                for (int i0 = 0; i0 <= l0; i0++) begin
                    k = (zz && i1[0]) ? l0 - i0 : i0;
                    wq.push_back(15'(b + i2 * s2 + i1 * s1 + k * s0));
                end
    endtask

    task automatic setcfg(input int b, input int s0, input int s1, input int s2,
                          input int l0, input int l1, input int l2);
        baseaddr = addr_t'(b);
        stride_0 = stride_t'(s0);
        stride_1 = stride_t'(s1);
        stride_2 = stride_t'(s2);
        length_0 = len_t'(l0);
        length_1 = len_t'(l1);
        length_2 = len_t'(l2);
    endtask

    // Load, step through the whole walk (optional 5-cycle gap), finish.
    task automatic walk(input int b, input int s0, input int s1, input int s2,
                        input int l0, input int l1, input int l2,
                        input bit zz, input int gap_at);
        int n;
        gen(b, s0, s1, s2, l0, l1, l2, zz);
        n = wq.size();
        setcfg(b, s0, s1, s2, l0, l1, l2);
        cyc(1'b1, 1'b0, {wq[0], 1'b1, n == 1, 1'b0});
        setcfg(777, 3, 5, 7, 9, 9, 9);
        for (int i = 1; i < n; i++) begin
            if (i == gap_at)
                repeat (5) cyc(1'b0, 1'b0, {wq[i-1], 1'b1, 1'b0, 1'b0});
            cyc(1'b0, 1'b1, {wq[i], 1'b1, i == n - 1, 1'b0});
        end
        cyc(1'b0, 1'b1, {wq[n-1], 1'b0, 1'b0, 1'b1});
        cyc(1'b0, 1'b0, {wq[n-1], 1'b0, 1'b0, 1'b0});
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        step = 1'b0;
        setcfg(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_addr", int'(addr_out), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_last", int'(last), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        walk(100, 1, 10, 100, 2, 1, 1, 1'b0, 4);
        walk(2, 'h7FFF, 0, 0, 3, 0, 0, 1'b0, -1);
        walk(32760, 3, 0, 0, 4, 0, 0, 1'b0, -1);
        walk(9, 0, 0, 0, 0, 0, 0, 1'b0, -1);
`ifdef INAGU_ZIGZAG_EN
        walk(100, 1, 10, 0, 2, 1, 0, 1'b1, -1);
        walk(50, 2, 20, 300, 2, 2, 1, 1'b1, 5);
`endif

        // Reload mid-walk with step in the same cycle.
        gen(100, 1, 10, 100, 2, 1, 1, 1'b0);
        setcfg(100, 1, 10, 100, 2, 1, 1);
        cyc(1'b1, 1'b0, {wq[0], 1'b1, 1'b0, 1'b0});
        for (int i = 1; i <= 3; i++)
            cyc(1'b0, 1'b1, {wq[i], 1'b1, 1'b0, 1'b0});
        setcfg(500, 0, 0, 0, 0, 0, 0);
        cyc(1'b1, 1'b1, {15'd500, 1'b1, 1'b1, 1'b0});
        cyc(1'b0, 1'b1, {15'd500, 1'b0, 1'b0, 1'b1});
        cyc(1'b0, 1'b0, {15'd500, 1'b0, 1'b0, 1'b0});

        // Async reset between edges mid-walk.
        setcfg(100, 1, 10, 100, 2, 1, 1);
        cyc(1'b1, 1'b0, {15'd100, 1'b1, 1'b0, 1'b0});
        cyc(1'b0, 1'b1, {15'd101, 1'b1, 1'b0, 1'b0});
        #2;
        rst = 1'b1;
        #1;
        chk("arst_addr", int'(addr_out), 0);
        chk("arst_valid", int'(valid), 0);
        chk("arst_last", int'(last), 0);
        chk("arst_done", int'(done), 0);
        rst = 1'b0;
        repeat (3) cyc(1'b0, 1'b1, {15'd0, 1'b0, 1'b0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
